// File: rtl/div_unit.sv
// Iterative restoring divider for RISC-V DIV/DIVU/REM/REMU with start/busy/done handshake.
// One quotient bit per cycle; result and NZCV flags are registered at the FIX step.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] DATA_A,
    input  logic [WIDTH-1:0] DATA_B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] OUT,
    output logic [3:0]       Flags
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e           state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] dvd_q;   // dividend magnitude, becomes the quotient
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH:0]   rem_q;
    logic [CW-1:0]    cnt_q;
    logic             qsign_q;
    logic             rsign_q;
    logic             dz_q;
    logic             ovf_q;

    // Operand preparation at acceptance
    logic             is_signed;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             div_zero;
    logic             overflow;

    always_comb begin
        is_signed = ~op[0];
        sign_a    = is_signed & DATA_A[WIDTH-1];
        sign_b    = is_signed & DATA_B[WIDTH-1];
        mag_a     = sign_a ? -DATA_A : DATA_A;
        mag_b     = sign_b ? -DATA_B : DATA_B;
        div_zero  = (DATA_B == '0);
        overflow  = is_signed && (DATA_A == {1'b1, {(WIDTH-1){1'b0}}}) && (DATA_B == '1);
    end

    // One restoring step; the extra remainder bit keeps the compare exact
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;
    logic           ge;

    always_comb begin
        rem_sh = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, dsr_q};
        ge     = ~diff[WIDTH];
    end

    // Final result selection
    logic [WIDTH-1:0] raw_res;
    logic             neg_res;
    logic [WIDTH-1:0] fix_res;
    logic             fix_c;
    logic             fix_v;

    always_comb begin
        raw_res = op_q[1] ? rem_q[WIDTH-1:0] : dvd_q;
        neg_res = op_q[1] ? rsign_q : qsign_q;
        fix_res = neg_res ? -raw_res : raw_res;
        fix_c   = 1'b0;
        fix_v   = 1'b0;
        if (dz_q) begin
            fix_res = op_q[1] ? a_q : '1;
            fix_c   = 1'b1;
        end else if (ovf_q) begin
            fix_res = op_q[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
            fix_v   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b0;
            OUT     <= '0;
            Flags   <= 4'b0100;
            op_q    <= 2'b00;
            a_q     <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        busy    <= 1'b1;
                        op_q    <= op;
                        a_q     <= DATA_A;
                        dvd_q   <= mag_a;
                        dsr_q   <= mag_b;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        qsign_q <= sign_a ^ sign_b;
                        rsign_q <= sign_a;
                        dz_q    <= div_zero;
                        ovf_q   <= overflow & ~div_zero;
                        state   <= (div_zero || overflow) ? StFix : StCalc;
                    end
                end
                StCalc: begin
                    rem_q <= ge ? diff : rem_sh;
                    dvd_q <= {dvd_q[WIDTH-2:0], ge};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastIter) begin
                        state <= StFix;
                    end
                end
                StFix: begin
                    OUT   <= fix_res;
                    Flags <= {fix_res[WIDTH-1], fix_res == '0, fix_c, fix_v};
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed results, flags and latencies.
module tb_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] DATA_A;
    logic [31:0] DATA_B;
    logic        busy;
    logic        done;
    logic [31:0] OUT;
    logic [3:0]  Flags;

    int n_checks;
    int n_bad;

    div_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .DATA_A (DATA_A),
        .DATA_B (DATA_B),
        .busy   (busy),
        .done   (done),
        .OUT    (OUT),
        .Flags  (Flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive a request now (just after an edge); it is sampled at the next rising edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op     = o;
        DATA_A = a;
        DATA_B = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done && cyc < 100);
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_out,
                       input logic [3:0] exp_flags, input int exp_lat);
        int cyc;
        issue(o, a, b);
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
        wait_done(tag, cyc);
        check({tag, "_out"}, OUT, exp_out);
        check({tag, "_flags"}, {28'b0, Flags}, {28'b0, exp_flags});
        check({tag, "_lat"}, cyc, exp_lat);
    endtask

    initial begin
        int cyc;
        int extra;
        n_checks = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        op       = 2'b00;
        DATA_A   = '0;
        DATA_B   = '0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_out", OUT, 32'd0);
        check("rst_flags", {28'b0, Flags}, 32'h4);
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", {31'b0, busy}, 32'd0);
        check("idle_out", OUT, 32'd0);
        check("idle_flags", {28'b0, Flags}, 32'h4);

        // Normal operations
        run("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 4'b1000, 33);
        @(posedge clk);
        #1;
        check("done_pulse", {31'b0, done}, 32'd0);
        check("out_hold", OUT, 32'hFFFF_FFFD);
        run("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 4'b1000, 33);
        run("divu_big",   2'b01, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 4'b0000, 33);
        run("remu_big",   2'b11, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 4'b0000, 33);
        run("div_100_m7", 2'b00, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 4'b1000, 33);
        run("rem_100_m7", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002, 4'b0000, 33);

        // Special cases
        run("div_by0",    2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 4'b1010, 1);
        run("remu_by0",   2'b11, 32'd5, 32'd0, 32'h0000_0005, 4'b0010, 1);
        run("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4'b1001, 1);
        run("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0101, 1);

        // Operand change and stray start during CALC: 1000 / 10 = 100
        issue(2'b01, 32'd1000, 32'd10);
        repeat (5) @(posedge clk);
        #1;
        DATA_A = 32'd0;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        wait_done("midcalc", cyc);
        check("midcalc_out", OUT, 32'd100);
        check("midcalc_lat", cyc, 27);
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        check("midcalc_single_done", extra, 0);

        // Back-to-back: new start in the done cycle
        issue(2'b01, 32'd77, 32'd7);
        wait_done("b2b_first", cyc);
        check("b2b_first_out", OUT, 32'd11);
        issue(2'b11, 32'd77, 32'd5);
        check("b2b_second_busy", {31'b0, busy}, 32'd1);
        wait_done("b2b_second", cyc);
        check("b2b_second_out", OUT, 32'd2);
        check("b2b_second_lat", cyc, 33);

        // Reset at iteration 10 aborts without done
        issue(2'b01, 32'd1234, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_out", OUT, 32'd0);
        check("abort_flags", {28'b0, Flags}, 32'h4);
        check("abort_busy", {31'b0, busy}, 32'd0);
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        check("abort_no_done", extra, 0);
        check("abort_out_hold", OUT, 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
